// File: rtl/spi_master_ctrl.sv
// SPI master controller: serialises 10-bit host commands onto MOSI inside an
// SS_n frame and, for read-data commands, collects an 8-bit reply from MISO.
module spi_master_ctrl #(
    parameter int RD_WAIT  = 2,
    parameter int IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       MOSI,
    output logic       SS_n,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_WAIT,
        S_RECV,
        S_GAP
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [9:0] tx_shift;
    logic [1:0] opcode;
    logic [7:0] rx_shift;
    logic       ss_n_d;
    logic       mosi_d;

    // State register; the shared counter restarts on every state change.
    // Reset parks the FSM in GAP so SS_n gets its idle time after any abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_GAP;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? 4'd0 : cnt + 4'd1;
        end
    end

    // Next-state decode: each timed state leaves when its counter hits the last cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (cmd_valid) next_state = S_START;
            S_START: next_state = S_SHIFT;
            S_SHIFT: if (cnt == 4'd9) next_state = (opcode == 2'b11) ? S_WAIT : S_GAP;
            S_WAIT:  if (cnt == WAIT_LAST) next_state = S_RECV;
            S_RECV:  if (cnt == 4'd7) next_state = S_GAP;
            S_GAP:   if (cnt == GAP_LAST) next_state = S_IDLE;
            default: next_state = S_GAP;
        endcase
    end

    // Output decode from the next state so the registered pins line up with the state they belong to.
    always_comb begin
        ss_n_d = (next_state == S_IDLE) || (next_state == S_GAP);
        mosi_d = 1'b0;
        if (next_state == S_SHIFT) begin
            mosi_d = (state == S_START) ? tx_shift[9] : tx_shift[8];
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Datapath: command latch, transmit shifter, receive shifter and registered pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            tx_shift  <= 10'd0;
            opcode    <= 2'b00;
            rx_shift  <= 8'h00;
        end else begin
            SS_n      <= ss_n_d;
            MOSI      <= mosi_d;
            rsp_valid <= 1'b0;
            if (state == S_IDLE && cmd_valid) begin
                tx_shift <= cmd_data;
                opcode   <= cmd_data[9:8];
            end else if (state == S_SHIFT) begin
                tx_shift <= {tx_shift[8:0], 1'b0};
            end
            if (state == S_RECV) begin
                rx_shift <= {rx_shift[6:0], MISO};
                if (cnt == 4'd7) begin
                    rsp_data  <= {rx_shift[6:0], MISO};
                    rsp_valid <= 1'b1;
                end
            end
        end
    end

endmodule
